// File: rtl/data_decimator.sv
// rtl/data_decimator.sv - ADC sample decimator with sample, peak-max and peak-min window modes.
module data_decimator #(
  parameter int DATA_W = 12,
  parameter int RATE_W = 16
) (
  input  logic              ad_clk,
  input  logic              rst,
  input  logic              en,
  input  logic [RATE_W-1:0] deci_rate,
  input  logic [1:0]        deci_mode,
  input  logic [DATA_W-1:0] ad_data,
  output logic              deci_valid,
  output logic [DATA_W-1:0] deci_data,
  output logic              clip
);

  logic [RATE_W-1:0] cnt;
  logic [RATE_W-1:0] n_lat;
  logic [1:0]        mode_lat;
  logic [DATA_W-1:0] run_first;
  logic [DATA_W-1:0] run_max;
  logic [DATA_W-1:0] run_min;
  logic              run_clip;

  logic              win_start;
  logic [RATE_W-1:0] n_eff;
  logic [1:0]        mode_eff;
  logic              win_last;
  logic              sample_clip;
  logic [DATA_W-1:0] win_first;
  logic [DATA_W-1:0] win_max;
  logic [DATA_W-1:0] win_min;
  logic              win_clip;
  logic [DATA_W-1:0] result;

  // At cnt=0 the live inputs define the window, so the first sample already uses them.
  always_comb begin
    win_start   = (cnt == '0);
    n_eff       = n_lat;
    mode_eff    = mode_lat;
    if (win_start) begin
      n_eff    = (deci_rate == '0) ? RATE_W'(1) : deci_rate;
      mode_eff = deci_mode;
    end
    win_last    = (cnt == n_eff - RATE_W'(1));
    sample_clip = (ad_data == '0) || (ad_data == '1);
    win_first   = win_start ? ad_data : run_first;
    win_max     = ad_data;
    win_min     = ad_data;
    win_clip    = sample_clip;
    if (!win_start) begin
      win_max  = (run_max > ad_data) ? run_max : ad_data;
      win_min  = (run_min < ad_data) ? run_min : ad_data;
      win_clip = run_clip | sample_clip;
    end
    case (mode_eff)
      2'b01:   result = win_max;
      2'b10:   result = win_min;
      default: result = win_first;
    endcase
  end

  always_ff @(posedge ad_clk) begin
    if (rst) begin
      cnt        <= '0;
      n_lat      <= '0;
      mode_lat   <= '0;
      run_first  <= '0;
      run_max    <= '0;
      run_min    <= '0;
      run_clip   <= 1'b0;
      deci_valid <= 1'b0;
      deci_data  <= '0;
      clip       <= 1'b0;
    end else begin
      deci_valid <= 1'b0;
      if (en) begin
        if (win_start) begin
          n_lat    <= n_eff;
          mode_lat <= mode_eff;
        end
        run_first <= win_first;
        run_max   <= win_max;
        run_min   <= win_min;
        run_clip  <= win_clip;
        if (win_last) begin
          cnt        <= '0;
          deci_valid <= 1'b1;
          deci_data  <= result;
          clip       <= win_clip;
        end else begin
          cnt <= cnt + RATE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_data_decimator.sv
// tb/tb_data_decimator.sv - directed vector bench for data_decimator.
module tb_data_decimator;

  logic        ad_clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] deci_rate = '0;
  logic [1:0]  deci_mode = '0;
  logic [11:0] ad_data = '0;
  logic        deci_valid;
  logic [11:0] deci_data;
  logic        clip;

  int n_cmp = 0;
  int n_bad = 0;

  data_decimator #(.DATA_W(12), .RATE_W(16)) dut (
    .ad_clk     (ad_clk),
    .rst        (rst),
    .en         (en),
    .deci_rate  (deci_rate),
    .deci_mode  (deci_mode),
    .ad_data    (ad_data),
    .deci_valid (deci_valid),
    .deci_data  (deci_data),
    .clip       (clip)
  );

  always #5 ad_clk = ~ad_clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] rate;
    logic [1:0]  mode;
    logic [11:0] data;
    logic        ev;
    logic [11:0] ed;
    logic        ec;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [15:0] rt, input logic [1:0] md,
                     input logic [11:0] d, input logic ev, input logic [11:0] ed, input logic ec);
    vec_t v;
    v.rst = r; v.en = e; v.rate = rt; v.mode = md; v.data = d;
    v.ev = ev; v.ed = ed; v.ec = ec;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then compare the outputs produced by that edge.
  task automatic step(input string name, input logic r, input logic e, input logic [15:0] rt,
                      input logic [1:0] md, input logic [11:0] d,
                      input logic ev, input logic [11:0] ed, input logic ec);
    rst = r; en = e; deci_rate = rt; deci_mode = md; ad_data = d;
    @(posedge ad_clk);
    #1;
    n_cmp++;
    if (deci_valid !== ev || deci_data !== ed || clip !== ec) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b data=%0d clip=%0b, want valid=%0b data=%0d clip=%0b",
               name, deci_valid, deci_data, clip, ev, ed, ec);
    end
  endtask

  initial begin
    // reset state
    add(1, 0, 0, 0, 0,    0, 0, 0);
    add(1, 1, 1, 0, 123,  0, 0, 0);
    // N=1 ramp, sample mode: pulse every cycle, data one cycle behind
    for (int i = 0; i < 6; i++)
      add(0, 1, 1, 0, 12'(i), 1, 12'(i), (i == 0));
    // N=4 peak-max 5,9,3,7
    add(0, 1, 4, 1, 5, 0, 5, 0);
    add(0, 1, 4, 1, 9, 0, 5, 0);
    add(0, 1, 4, 1, 3, 0, 5, 0);
    add(0, 1, 4, 1, 7, 1, 9, 0);
    // N=4 peak-min 5,9,3,7
    add(0, 1, 4, 2, 5, 0, 9, 0);
    add(0, 1, 4, 2, 9, 0, 9, 0);
    add(0, 1, 4, 2, 3, 0, 9, 0);
    add(0, 1, 4, 2, 7, 1, 3, 0);
    // N=4 sample mode, rate changed to 2 at cnt=1
    add(0, 1, 4, 0, 10, 0, 3, 0);
    add(0, 1, 2, 0, 11, 0, 3, 0);
    add(0, 1, 2, 0, 12, 0, 3, 0);
    add(0, 1, 2, 0, 13, 1, 10, 0);
    add(0, 1, 2, 0, 14, 0, 10, 0);
    add(0, 1, 2, 0, 15, 1, 14, 0);
    add(0, 1, 2, 0, 16, 0, 14, 0);
    add(0, 1, 2, 0, 17, 1, 16, 0);
    // clip from a mid-window 4095, then a clean window
    add(0, 1, 4, 0, 100,  0, 16, 0);
    add(0, 1, 4, 0, 4095, 0, 16, 0);
    add(0, 1, 4, 0, 200,  0, 16, 0);
    add(0, 1, 4, 0, 300,  1, 100, 1);
    add(0, 1, 4, 0, 100,  0, 100, 1);
    add(0, 1, 4, 0, 200,  0, 100, 1);
    add(0, 1, 4, 0, 300,  0, 100, 1);
    add(0, 1, 4, 0, 400,  1, 100, 0);
    // reserved mode behaves as sample mode
    add(0, 1, 2, 3, 50, 0, 100, 0);
    add(0, 1, 2, 3, 60, 1, 50, 0);
    // rate 0 means N=1
    add(0, 1, 0, 1, 77, 1, 77, 0);
    add(0, 1, 0, 1, 78, 1, 78, 0);
    add(0, 0, 0, 1, 79, 0, 78, 0);

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec[%0d]", i), vecs[i].rst, vecs[i].en, vecs[i].rate, vecs[i].mode,
           vecs[i].data, vecs[i].ev, vecs[i].ed, vecs[i].ec);

    // en gap of 3 cycles after the second sample; ignored data must not leak in
    step("gap_s0", 0, 1, 4, 1, 5,    0, 78, 0);
    step("gap_s1", 0, 1, 4, 1, 9,    0, 78, 0);
    step("gap_h0", 0, 0, 4, 1, 4095, 0, 78, 0);
    step("gap_h1", 0, 0, 4, 1, 4095, 0, 78, 0);
    step("gap_h2", 0, 0, 4, 1, 4095, 0, 78, 0);
    step("gap_s2", 0, 1, 4, 1, 3,    0, 78, 0);
    step("gap_s3", 0, 1, 4, 1, 7,    1, 9, 0);
    step("gap_idle", 0, 0, 4, 1, 7,  0, 9, 0);

    // reset at cnt=2 discards the partial window; next window spans 4 samples
    step("rst_s0", 0, 1, 4, 0, 20, 0, 9, 0);
    step("rst_s1", 0, 1, 4, 0, 21, 0, 9, 0);
    step("rst_hit", 1, 1, 4, 0, 22, 0, 0, 0);
    step("rst_w0", 0, 1, 4, 0, 30, 0, 0, 0);
    step("rst_w1", 0, 1, 4, 0, 31, 0, 0, 0);
    step("rst_w2", 0, 1, 4, 0, 32, 0, 0, 0);
    step("rst_w3", 0, 1, 4, 0, 33, 1, 30, 0);
    step("rst_after", 0, 0, 4, 0, 34, 0, 30, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_decimator.md
DATA_DECIMATOR -- requirements
Module: data_decimator

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12, meaning ADC sample width.
REQ-002 The block SHALL have parameter RATE_W, default 16, meaning decimation-factor width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port ad_clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit, the sample-accept enable (acquisition running).
REQ-007 The block SHALL have port deci_rate, input, RATE_W bits, the decimation factor N, where 0 and 1 both mean N=1.
REQ-008 The block SHALL have port deci_mode, input, 2 bits: 00 = sample, 01 = peak-max, 10 = peak-min, 11 = reserved (behaves as 00).
REQ-009 The block SHALL have port ad_data, input, DATA_W bits, the ADC sample, valid every ad_clk cycle.
REQ-010 The block SHALL have port deci_valid, output, 1 bit, a one-cycle pulse per completed window (feeds the waveform store).
REQ-011 The block SHALL have port deci_data, output, DATA_W bits, the window result, held until the next pulse.
REQ-012 The block SHALL have port clip, output, 1 bit, asserted when any sample in the reported window equalled 0 or 2^DATA_W-1; it updates with deci_valid.

Function
REQ-013 A sample SHALL be accepted in a cycle iff en=1 and rst=0; in any other cycle no block state other than deci_valid changes.
REQ-014 Window position counter cnt SHALL range 0..N_lat-1 and advance by one per accepted sample.
REQ-015 On the accepted sample with cnt=0, deci_rate and deci_mode SHALL be latched into N_lat and mode_lat; changes at any other time take effect at the next window only.
REQ-016 N_lat SHALL be max(deci_rate,1); no other value is treated specially.
REQ-017 Sample mode SHALL report the first sample of the window (the one accepted at cnt=0).
REQ-018 Peak-max mode SHALL report the unsigned maximum of all N_lat samples, including the last one.
REQ-019 Peak-min mode SHALL report the unsigned minimum of all N_lat samples, including the last one.
REQ-020 On the accepted sample with cnt=N_lat-1, the block SHALL do all of the following:
- register the result into deci_data;
- register clip from the whole window including this sample;
- set deci_valid=1 in the next cycle only;
- reset cnt to 0.
REQ-021 Latency SHALL be 1 cycle: deci_valid and deci_data become visible on the edge after the window's last sample.
REQ-022 For N_lat=1 the block SHALL pulse deci_valid after every accepted sample, with deci_data equal to that sample.
REQ-023 deci_valid SHALL never be high for two consecutive cycles unless N_lat=1.
REQ-024 If en=0 in mid-window, the block SHALL hold cnt and the running max/min/clip, and complete the window correctly when en returns to 1.
REQ-025 When the last sample is accepted, the block SHALL initialise the running max/min and clip state of the next window from the next accepted sample (cnt=0), not from stale state.
REQ-026 cnt SHALL be RATE_W bits wide, and comparison against N_lat-1 SHALL not overflow when deci_rate is at its maximum value (2^RATE_W-1).

Reset
REQ-027 While rst=1, the block SHALL drive deci_valid=0, deci_data=0 and clip=0, and clear cnt, N_lat, mode_lat and the running state on the next edge.
REQ-028 After rst deasserts, the first accepted sample SHALL start a new window at cnt=0; a rst asserted mid-window discards the partial window without emitting a pulse.

Verification
REQ-029 The bench SHALL cover: N=1, sample mode, en=1, ad_data ramp 0,1,2,... -> deci_valid high every cycle, deci_data one cycle behind ad_data.
REQ-030 The bench SHALL cover: N=4, peak-max mode, samples 5,9,3,7 -> single pulse the cycle after 7 with deci_data=9; repeat in peak-min mode -> deci_data=3.
REQ-031 The bench SHALL cover: N=4, sample mode, deci_rate changed to 2 at cnt=1 -> current window completes with 4 samples, subsequent pulses every 2 samples.
REQ-032 The bench SHALL cover: N=4, peak-max, en=0 for 3 cycles after the second sample -> pulse delayed by exactly 3 cycles with the result unchanged.
REQ-033 The bench SHALL cover: a window containing 4095 (DATA_W=12) -> clip=1 with that pulse; the next window with no 0/4095 -> clip=0.
REQ-034 The bench SHALL cover: rst asserted at cnt=2 of N=4 -> outputs 0 the next cycle, no pulse emitted, and the next window after release spans exactly 4 accepted samples.
